// File: rtl/measure_pkg.sv
// Shared definitions for the port-0 measurement generator: frame type codes,
// scheduler state encoding and clock-rate constants.
package measure_pkg;

  localparam int unsigned ONE_SEC_CYCLES = 156250000;

  localparam logic [1:0] FT_ARP = 2'd0;
  localparam logic [1:0] FT_V4  = 2'd1;
  localparam logic [1:0] FT_V6  = 2'd2;

  localparam logic [47:0] MAC_BCAST = 48'hffff_ffff_ffff;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_ARP  = 3'd1,
    ST_WAIT_ARP = 3'd2,
    ST_SEND     = 3'd3,
    ST_GAP      = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sched_timer.sv
// 32-bit loadable down-counter with a zero flag; shared by the ARP reply wait
// and the inter-frame gap, which never overlap.
module sched_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_dec,
  output logic        o_zero
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 32'd1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/tx_sched.sv
// Port-0 transmit scheduler: picks the next frame (ARP / IPv4 / IPv6), runs the
// ARP resolve/retry sequence and the inter-frame gap, and owns per-frame headers.
module tx_sched
  import measure_pkg::*;
#(
  parameter int unsigned ARP_TIMEOUT = ONE_SEC_CYCLES,
  parameter int unsigned ARP_RETRIES = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tx_enable,
  input  logic        tx_ipv6,
  input  logic        tx_fullroute,
  input  logic        tx_req_arp,
  input  logic [31:0] tx_inter_frame_gap,
  input  logic        arp_flush,
  input  logic        sec_oneshot,
  input  logic        arp_reply_valid,
  input  logic [47:0] arp_reply_mac,
  input  logic        frame_ack,
  input  logic        frame_done,
  output logic        frame_req,
  output logic [1:0]  frame_type,
  output logic [47:0] dst_mac,
  output logic [15:0] ipv4_id,
  output logic [23:0] full_ipv4,
  output logic        arp_resolved,
  output logic        arp_fail,
  output logic [31:0] tx_pps,
  output logic [2:0]  dbg_state
);

  // Handshake: frame_req stays high until frame_ack is sampled high in the same
  // cycle; after that the frame is owned by the generator until frame_done.
  localparam logic [31:0] ARP_LOAD    = 32'(ARP_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(ARP_RETRIES);

  sched_state_t r_state;
  logic         r_frame_req;
  logic         r_acked;
  logic         r_arp_resolved;
  logic         r_arp_fail;
  logic         r_flush_pend;
  logic [1:0]   r_frame_type;
  logic [47:0]  r_dst_mac;
  logic [15:0]  r_ipv4_id;
  logic [23:0]  r_full_ipv4;
  logic [31:0]  r_tx_pps;
  logic [31:0]  r_frame_cnt;
  logic [7:0]   r_retry;

  logic         w_ack;
  logic         w_done_arp;
  logic         w_frame_sent;
  logic         w_gap_load;
  logic         w_tmr_load;
  logic         w_tmr_dec;
  logic         w_tmr_zero;
  logic [31:0]  w_tmr_val;
  logic [1:0]   w_send_type;

  always_comb begin
    w_ack        = r_frame_req & frame_ack;
    w_done_arp   = (r_state == ST_REQ_ARP) & r_acked & frame_done;
    w_frame_sent = (r_state == ST_SEND) & r_acked & frame_done;
    w_gap_load   = w_frame_sent & tx_enable & (tx_inter_frame_gap != '0);
    w_tmr_load   = w_done_arp | w_gap_load;
    w_tmr_val    = w_done_arp ? ARP_LOAD : (tx_inter_frame_gap - 32'd1);
    w_tmr_dec    = (r_state == ST_WAIT_ARP) | (r_state == ST_GAP);
    w_send_type  = tx_ipv6 ? FT_V6 : FT_V4;
  end

  sched_timer u_timer (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state        <= ST_IDLE;
      r_frame_req    <= 1'b0;
      r_acked        <= 1'b0;
      r_arp_resolved <= 1'b0;
      r_arp_fail     <= 1'b0;
      r_flush_pend   <= 1'b0;
      r_frame_type   <= FT_ARP;
      r_dst_mac      <= MAC_BCAST;
      r_ipv4_id      <= '0;
      r_full_ipv4    <= '0;
      r_tx_pps       <= '0;
      r_frame_cnt    <= '0;
      r_retry        <= '0;
    end else begin
      // A pending request keeps its MAC; the broadcast reload waits for the ack.
      if ((arp_flush || r_flush_pend) && (r_state != ST_WAIT_ARP)) begin
        r_arp_resolved <= 1'b0;
        if (r_frame_req) begin
          r_flush_pend <= 1'b1;
        end else begin
          r_dst_mac    <= MAC_BCAST;
          r_flush_pend <= 1'b0;
        end
      end

      if (sec_oneshot) begin
        r_tx_pps    <= r_frame_cnt;
        r_frame_cnt <= w_frame_sent ? 32'd1 : 32'd0;
      end else if (w_frame_sent && (r_frame_cnt != '1)) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end

      case (r_state)
        ST_IDLE: begin
          r_frame_req <= 1'b0;
          r_acked     <= 1'b0;
          if (!tx_enable) begin
            r_arp_fail <= 1'b0;
            r_retry    <= '0;
          end else if (!r_arp_fail) begin
            r_frame_req <= 1'b1;
            if (tx_req_arp && !tx_ipv6 && !r_arp_resolved) begin
              r_state      <= ST_REQ_ARP;
              r_frame_type <= FT_ARP;
            end else begin
              r_state      <= ST_SEND;
              r_frame_type <= w_send_type;
            end
          end
        end

        ST_REQ_ARP: begin
          if (!r_acked) begin
            if (w_ack) begin
              r_frame_req <= 1'b0;
              r_acked     <= 1'b1;
            end else if (!tx_enable) begin
              r_frame_req <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end else if (frame_done) begin
            r_acked <= 1'b0;
            r_state <= ST_WAIT_ARP;
          end
        end

        ST_WAIT_ARP: begin
          if (arp_reply_valid) begin
            r_dst_mac      <= arp_reply_mac;
            r_arp_resolved <= 1'b1;
            r_retry        <= '0;
            r_state        <= ST_SEND;
            r_frame_type   <= w_send_type;
            r_frame_req    <= 1'b1;
          end else if (w_tmr_zero) begin
            r_retry <= r_retry + 8'd1;
            if ((r_retry + 8'd1) == RETRY_LIMIT) begin
              r_arp_fail <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_state      <= ST_REQ_ARP;
              r_frame_type <= FT_ARP;
              r_frame_req  <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          if (!r_acked) begin
            if (w_ack) begin
              r_frame_req <= 1'b0;
              r_acked     <= 1'b1;
            end else if (!tx_enable) begin
              r_frame_req <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end else if (frame_done) begin
            r_acked <= 1'b0;
            if (r_frame_type == FT_V4) begin
              r_ipv4_id <= r_ipv4_id + 16'd1;
              if (tx_fullroute) r_full_ipv4 <= r_full_ipv4 + 24'd1;
            end
            if (!tx_enable) begin
              r_state <= ST_IDLE;
            end else if (tx_inter_frame_gap == '0) begin
              r_frame_type <= w_send_type;
              r_frame_req  <= 1'b1;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (!tx_enable) begin
            r_state <= ST_IDLE;
          end else if (w_tmr_zero) begin
            r_state      <= ST_SEND;
            r_frame_type <= w_send_type;
            r_frame_req  <= 1'b1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_frame_req <= 1'b0;
          r_acked     <= 1'b0;
        end
      endcase
    end
  end

  assign frame_req    = r_frame_req;
  assign frame_type   = r_frame_type;
  assign dst_mac      = r_dst_mac;
  assign ipv4_id      = r_ipv4_id;
  assign full_ipv4    = r_full_ipv4;
  assign arp_resolved = r_arp_resolved;
  assign arp_fail     = r_arp_fail;
  assign tx_pps       = r_tx_pps;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched: a small generator model acks and completes
// frames; a monitor logs request rises and done pulses for timing checks.
`timescale 1ns/1ps
module tb_tx_sched;
  import measure_pkg::*;

  localparam int unsigned TMO = 100;
  localparam logic [47:0] REPLY_MAC = 48'h003776000101;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        tx_enable, tx_ipv6, tx_fullroute, tx_req_arp;
  logic [31:0] tx_inter_frame_gap;
  logic        arp_flush, sec_oneshot, arp_reply_valid;
  logic [47:0] arp_reply_mac;
  logic        frame_ack, frame_done;
  logic        frame_req;
  logic [1:0]  frame_type;
  logic [47:0] dst_mac;
  logic [15:0] ipv4_id;
  logic [23:0] full_ipv4;
  logic        arp_resolved, arp_fail;
  logic [31:0] tx_pps;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit gen_on      = 1'b0;
  int gen_len     = 10;
  bit sec_on_done = 1'b0;
  logic prev_req  = 1'b0;

  int          rise_cyc_q[$];
  int          done_cyc_q[$];
  logic [1:0]  type_q[$];
  logic [15:0] id_q[$];
  logic [23:0] fip_q[$];
  logic [47:0] mac_q[$];
  logic [63:0] exp_q[$];

  tx_sched #(.ARP_TIMEOUT(TMO), .ARP_RETRIES(3)) dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .tx_enable          (tx_enable),
    .tx_ipv6            (tx_ipv6),
    .tx_fullroute       (tx_fullroute),
    .tx_req_arp         (tx_req_arp),
    .tx_inter_frame_gap (tx_inter_frame_gap),
    .arp_flush          (arp_flush),
    .sec_oneshot        (sec_oneshot),
    .arp_reply_valid    (arp_reply_valid),
    .arp_reply_mac      (arp_reply_mac),
    .frame_ack          (frame_ack),
    .frame_done         (frame_done),
    .frame_req          (frame_req),
    .frame_type         (frame_type),
    .dst_mac            (dst_mac),
    .ipv4_id            (ipv4_id),
    .full_ipv4          (full_ipv4),
    .arp_resolved       (arp_resolved),
    .arp_fail           (arp_fail),
    .tx_pps             (tx_pps),
    .dbg_state          (dbg_state)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: log each frame_req rise with the header fields presented with it.
  always @(negedge sys_clk) begin
    if (frame_req && !prev_req) begin
      rise_cyc_q.push_back(cyc);
      type_q.push_back(frame_type);
      id_q.push_back(ipv4_id);
      fip_q.push_back(full_ipv4);
      mac_q.push_back(dst_mac);
    end
    prev_req <= frame_req;
  end

  // Generator model: ack in the request cycle, frame_done gen_len cycles later.
  initial begin
    frame_ack  = 1'b0;
    frame_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      frame_done = 1'b0;
      if (sec_on_done) begin
        sec_oneshot = 1'b0;
        sec_on_done = 1'b0;
      end
      if (gen_on && frame_req) begin
        frame_ack = 1'b1;
        @(negedge sys_clk);
        frame_ack = 1'b0;
        repeat (gen_len - 1) @(negedge sys_clk);
        frame_done = 1'b1;
        if (sec_on_done) sec_oneshot = 1'b1;
        done_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    rise_cyc_q.delete(); done_cyc_q.delete(); type_q.delete();
    id_q.delete(); fip_q.delete(); mac_q.delete(); exp_q.delete();
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rise_cyc_q.size() < n && k < budget) begin @(negedge sys_clk); k++; end
    check("wait_rises", 64'(rise_cyc_q.size()), 64'(n));
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (done_cyc_q.size() < n && k < budget) begin @(negedge sys_clk); k++; end
    check("wait_dones", 64'(done_cyc_q.size()), 64'(n));
  endtask

  task automatic wait_req(input logic level, input int budget);
    int k = 0;
    while (frame_req !== level && k < budget) begin @(negedge sys_clk); k++; end
    check("wait_req", 64'(frame_req), 64'(level));
  endtask

  task automatic stop_after_ack(input int n_done);
    wait_req(1'b0, 20);
    tx_enable = 1'b0;
    wait_dones(n_done, 50);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic pulse_sec();
    sec_oneshot = 1'b1;
    @(negedge sys_clk);
    sec_oneshot = 1'b0;
  endtask

  // Stimulus and checks
  initial begin
    sys_rst_n = 1'b0;
    tx_enable = 1'b0; tx_ipv6 = 1'b0; tx_fullroute = 1'b0; tx_req_arp = 1'b0;
    tx_inter_frame_gap = 32'd0;
    arp_flush = 1'b0; sec_oneshot = 1'b0; arp_reply_valid = 1'b0;
    arp_reply_mac = 48'd0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    check("rst_frame_req", frame_req, 0);
    check("rst_dst_mac", dst_mac, 48'hffffffffffff);
    check("rst_ipv4_id", ipv4_id, 0);
    check("rst_full_ipv4", full_ipv4, 0);
    check("rst_arp_resolved", arp_resolved, 0);
    check("rst_arp_fail", arp_fail, 0);
    check("rst_tx_pps", tx_pps, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Back-to-back IPv4, gap 0, then drop enable after the ack of frame 4
    gen_on = 1'b1;
    clear_q();
    tx_enable = 1'b1;
    wait_rises(4, 100);
    stop_after_ack(4);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(i));
    for (int i = 0; i < 4; i++) begin
      check("b2b_type", type_q[i], FT_V4);
      check("b2b_id", id_q[i], exp_q.pop_front());
    end
    for (int i = 0; i < 3; i++)
      check("b2b_spacing", 64'(rise_cyc_q[i+1] - done_cyc_q[i]), 1);
    repeat (20) @(negedge sys_clk);
    check("after_ack_no_req", 64'(rise_cyc_q.size()), 4);
    check("after_ack_state", dbg_state, ST_IDLE);
    check("after_ack_id", ipv4_id, 16'd4);
    pulse_sec();
    check("after_ack_pps", tx_pps, 32'd4);

    // Enable dropped while the request is still unacknowledged
    gen_on = 1'b0;
    clear_q();
    tx_enable = 1'b1;
    wait_req(1'b1, 10);
    tx_enable = 1'b0;
    @(negedge sys_clk);
    check("preack_req_drop", frame_req, 0);
    check("preack_state", dbg_state, ST_IDLE);
    check("preack_id", ipv4_id, 16'd4);
    gen_on = 1'b1;

    // Per-second rate: 7 frames, then a pulse coincident with frame_done
    clear_q();
    repeat (2) @(negedge sys_clk);
    tx_enable = 1'b1;
    wait_dones(7, 200);
    repeat (2) @(negedge sys_clk);
    pulse_sec();
    check("pps_7", tx_pps, 32'd7);
    sec_on_done = 1'b1;
    tx_enable = 1'b0;
    wait_dones(8, 50);
    repeat (3) @(negedge sys_clk);
    check("pps_coincide", tx_pps, 32'd0);
    check("pps_frames", 64'(rise_cyc_q.size()), 8);
    pulse_sec();
    check("pps_restart_1", tx_pps, 32'd1);

    // ARP resolve with a reply 50 cycles after the ARP frame
    clear_q();
    tx_req_arp = 1'b1;
    tx_enable = 1'b1;
    wait_dones(1, 100);
    repeat (49) @(negedge sys_clk);
    arp_reply_mac = REPLY_MAC;
    arp_reply_valid = 1'b1;
    @(negedge sys_clk);
    arp_reply_valid = 1'b0;
    wait_rises(2, 20);
    check("arp_first_type", type_q[0], FT_ARP);
    check("arp_then_v4", type_q[1], FT_V4);
    check("arp_req_mac", mac_q[1], REPLY_MAC);
    check("arp_resolved", arp_resolved, 1);
    check("arp_dst_mac", dst_mac, REPLY_MAC);
    stop_after_ack(2);

    // Flush in IDLE restores broadcast
    arp_flush = 1'b1;
    @(negedge sys_clk);
    arp_flush = 1'b0;
    check("flush_mac", dst_mac, 48'hffffffffffff);
    check("flush_resolved", arp_resolved, 0);

    // ARP with no reply: 3 requests, timeout spacing, then sticky failure
    clear_q();
    tx_enable = 1'b1;
    begin
      int k = 0;
      while (arp_fail !== 1'b1 && k < 1000) begin @(negedge sys_clk); k++; end
    end
    check("fail_set", arp_fail, 1);
    check("fail_state", dbg_state, ST_IDLE);
    check("fail_nreq", 64'(rise_cyc_q.size()), 3);
    for (int i = 0; i < 3; i++) check("fail_type", type_q[i], FT_ARP);
    for (int i = 0; i < 2; i++)
      check("fail_spacing", 64'(rise_cyc_q[i+1] - done_cyc_q[i]), 64'(TMO + 1));
    repeat (20) @(negedge sys_clk);
    check("fail_no_more_req", 64'(rise_cyc_q.size()), 3);
    tx_enable = 1'b0;
    tx_req_arp = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("fail_cleared", arp_fail, 0);

    // Gap 5 with full-route stepping across the 24-bit wrap
    force dut.r_full_ipv4 = 24'hfffffe;
    @(negedge sys_clk);
    release dut.r_full_ipv4;
    @(negedge sys_clk);
    check("fr_preset", full_ipv4, 24'hfffffe);
    clear_q();
    tx_inter_frame_gap = 32'd5;
    tx_fullroute = 1'b1;
    tx_enable = 1'b1;
    wait_rises(3, 200);
    stop_after_ack(3);
    exp_q.push_back(64'h00fffffe);
    exp_q.push_back(64'h00ffffff);
    exp_q.push_back(64'h00000000);
    for (int i = 0; i < 3; i++) check("fr_route", fip_q[i], exp_q.pop_front());
    for (int i = 0; i < 2; i++)
      check("gap_spacing", 64'(rise_cyc_q[i+1] - done_cyc_q[i]), 6);
    check("gap_first_id", id_q[0], 16'd13);
    check("fr_after", full_ipv4, 24'h000001);

    // Asynchronous reset while a request is pending
    gen_on = 1'b0;
    tx_enable = 1'b1;
    wait_req(1'b1, 10);
    #2 sys_rst_n = 1'b0;
    #1;
    check("areset_req", frame_req, 0);
    check("areset_id", ipv4_id, 0);
    check("areset_state", dbg_state, ST_IDLE);
    tx_enable = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_sched.md
# tx_sched

Transmit scheduler for the measurement port-0 generator. Decides which frame the XGMII frame generator emits next (ARP request, IPv4 test frame, IPv6 test frame) and when. Runs the ARP resolve/retry sequence and inter-frame gap timing. Owns the per-frame header variables (IPv4 ID, full-route destination index, resolved destination MAC) and the per-second TX frame rate. Sits between the PCI user registers and the frame generator, in the sys_clk domain.

## Interface
- ARP_TIMEOUT, 156250000: sys_clk cycles to wait for an ARP reply (1 s at 156.25 MHz).
- ARP_RETRIES, 3: ARP requests sent before declaring failure.
- sys_clk  in  1  156.25 MHz XGMII clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- tx_enable  in  1  run/stop for port-0 generation.
- tx_ipv6  in  1  select IPv6 test frames (no ARP in IPv6 mode).
- tx_fullroute  in  1  step the destination route index per IPv4 frame.
- tx_req_arp  in  1  resolve gateway MAC before sending IPv4.
- tx_inter_frame_gap  in  32  idle cycles between frames.
- arp_flush  in  1  pulse: forget the resolved MAC.
- sec_oneshot  in  1  one-cycle pulse each second.
- arp_reply_valid  in  1  pulse: ARP reply for gateway IP received.
- arp_reply_mac  in  48  MAC carried by that reply.
- frame_ack  in  1  generator has started the requested frame.
- frame_done  in  1  pulse: generator emitted the terminate word.
- frame_req  out  1  request one frame.
- frame_type  out  2  0 = ARP, 1 = IPv4, 2 = IPv6; valid while frame_req is high.
- dst_mac  out  48  destination MAC; reset 48'hffffffffffff.
- ipv4_id  out  16  IPv4 identification; reset 0.
- full_ipv4  out  24  route index; the destination is {full_ipv4, 8'h01}; reset 0.
- arp_resolved  out  1  reset 0.
- arp_fail  out  1  sticky; reset 0.
- tx_pps  out  32  frames sent in the last second; reset 0.

## Operation
- States: IDLE, REQ_ARP, WAIT_ARP, SEND, GAP. Reset state is IDLE. All outputs are registered.
- IDLE:
  - Stays in IDLE while tx_enable = 0 or arp_fail = 1.
  - When tx_enable = 1: go to REQ_ARP if tx_req_arp & ~tx_ipv6 & ~arp_resolved; otherwise go to SEND.
  - Clear arp_fail and the retry count when tx_enable = 0.
- REQ_ARP and SEND (request handshake):
  - Hold frame_req = 1 until frame_ack is sampled high, then drop frame_req.
  - Wait for frame_done.
  - frame_type is fixed on state entry; in SEND it is tx_ipv6 ? 2 : 1.
  - If tx_enable = 0 before the ack: withdraw frame_req and go to IDLE.
  - After the ack, a frame is never abandoned.
- REQ_ARP exit: on frame_done, go to WAIT_ARP and load the timer with ARP_TIMEOUT-1.
- WAIT_ARP:
  - arp_reply_valid: latch dst_mac, set arp_resolved = 1, go to SEND. A reply wins over a timeout in the same cycle.
  - Timer reaches 0: increment retry count. If the count equals ARP_RETRIES, set arp_fail and go to IDLE; otherwise go to REQ_ARP.
- SEND on frame_done:
  - frame counter +1.
  - If IPv4: ipv4_id +1, wrapping 16'hffff -> 0.
  - If IPv4 & tx_fullroute: full_ipv4 +1, wrapping 24'hffffff -> 0.
  - Next state: IDLE if tx_enable = 0; else SEND if gap = 0; else GAP, loading the timer with gap-1.
- GAP:
  - Timer decrements each cycle.
  - At 0: go to SEND if tx_enable = 1, else IDLE.
  - tx_enable = 0 aborts the gap immediately.
- arp_flush: sets dst_mac to broadcast and clears arp_resolved.
  - Outside WAIT_ARP it takes effect in the next cycle.
  - In WAIT_ARP it is ignored.
  - A frame already requested keeps its MAC.
- tx_pps: on sec_oneshot, tx_pps <= frame counter, and the counter restarts.
  - If frame_done coincides with sec_oneshot, the counter restarts at 1.
  - The counter saturates at 32'hffffffff.

## Timing
- frame_req rises 1 cycle after entry into REQ_ARP or SEND.
- Gap 0: the next frame_req rises in the cycle after frame_done.
- Gap N>0: exactly N cycles with frame_req = 0 between the frame_done cycle and the cycle frame_req rises.
- dst_mac / ipv4_id / full_ipv4 update in the cycle after the triggering pulse. They are stable while frame_req is high.
- ARP timeout: exactly ARP_TIMEOUT cycles after the REQ_ARP frame_done.
- Asynchronous reset mid-frame: frame_req drops immediately. The generator finishes or drops its frame independently.

## Structure
- Put these in shared package measure_pkg:
  - frame type codes FT_ARP / FT_V4 / FT_V6;
  - state encoding;
  - ONE_SEC_CYCLES = 156250000.
- One sub-module, sched_timer: a 32-bit loadable down-counter with a zero flag. It is shared by WAIT_ARP and GAP because those states are mutually exclusive.

## Test plan
- tx_req_arp=0, tx_ipv6=0, gap=0, generator acks immediately and signals done after 10 cycles.
  - Required: frame_type=1 back-to-back; ipv4_id increments 0,1,2…; frame_req rises 1 cycle after each done.
- tx_req_arp=1, ARP_TIMEOUT=100.
  - Reply with MAC 00:37:76:00:01:01 after 50 cycles.
  - Required: one ARP frame, then dst_mac=48'h003776000101, arp_resolved=1, and SEND with IPv4.
- ARP_TIMEOUT=100, ARP_RETRIES=3, no reply.
  - Required: 3 ARP frames spaced 100 cycles after each done, then arp_fail=1 and IDLE.
  - Required: toggling tx_enable clears arp_fail.
- gap=5, tx_fullroute=1, full_ipv4 preset near wrap (force 24'hfffffe).
  - Required: exactly 5 idle cycles between frames; full_ipv4 goes fffffe -> ffffff -> 000000.
- tx_enable dropped while waiting for ack.
  - Required: frame_req falls next cycle, then IDLE.
- tx_enable dropped after ack.
  - Required: frame completes; frame_done still counted; no further frame_req.
- sec_oneshot pulsed after 7 frames, then again coinciding with a frame_done.
  - Required: tx_pps=7, then the counter restarts at 1.
